// File: rtl/qdec_pkg.sv
// Shared types and constants for the quadrature decoder.
// Optional feature macro: QDEC_GLITCH_FILTER_EN (adds a per-input stability filter).
package qdec_pkg;

    // Decoder FSM: wait for the input pipeline to fill, then track phase changes.
    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_TRACK = 1'b1
    } qdec_state_e;

    // Phase codes, written as {a, b}.
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam int unsigned SYNC_STAGES = 2;

    // True when prev -> cur is one step of the A-leads-B (count up) sequence.
    function automatic logic is_up_step(input logic [1:0] prev, input logic [1:0] cur);
        logic up;
        up = 1'b0;
        case (prev)
            PH_00:   up = (cur == PH_10);
            PH_10:   up = (cur == PH_11);
            PH_11:   up = (cur == PH_01);
            default: up = (cur == PH_00);
        endcase
        return up;
    endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Bus between the encoder/control side (master) and the decoder (slave).
// Optional feature macro: QDEC_GLITCH_FILTER_EN (no effect on this interface).
interface quadrature_decoder_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 enc_a;
    logic                 enc_b;
    logic                 enable;
    logic                 clear;
    logic                 load;
    logic [CNT_WIDTH-1:0] load_value;
    logic [CNT_WIDTH-1:0] position;
    logic                 step;
    logic                 dir;
    logic                 err;
    logic                 err_sticky;

    modport master (
        output enc_a, enc_b, enable, clear, load, load_value,
        input  position, step, dir, err, err_sticky
    );

    modport slave (
        input  enc_a, enc_b, enable, clear, load, load_value,
        output position, step, dir, err, err_sticky
    );
endinterface

// File: rtl/qdec_input_filter.sv
// Synchronizer plus optional stability filter for one encoder phase.
// Optional feature macro: QDEC_GLITCH_FILTER_EN enables the stability filter.
module qdec_input_filter
    import qdec_pkg::*;
#(
    parameter int unsigned FILT_CYCLES = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_phase
);

    if (FILT_CYCLES < 1 || FILT_CYCLES > 15) begin : g_bad_filt_cycles
        $error("FILT_CYCLES must be in 1..15");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    // Metastability synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;

    // Accept a new level only after it has differed for FILT_CYCLES samples in a row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (w_sync == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(FILT_CYCLES - 1)) begin
            r_filt <= w_sync;
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_phase = r_filt;
`else
    assign o_phase = w_sync;
`endif

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature (A/B) decoder with 4x step decoding and a loadable up/down position counter.
// Optional feature macro: QDEC_GLITCH_FILTER_EN inserts a stability filter on each phase.
module quadrature_decoder
    import qdec_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned FILT_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    quadrature_decoder_if.slave qbus
);

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int unsigned FILL = 2 + FILT_CYCLES;
`else
    localparam int unsigned FILL = 2;
`endif

    logic                 w_a;
    logic                 w_b;
    logic [1:0]           w_phase;
    qdec_state_e          r_state;
    qdec_state_e          w_state_next;
    logic [4:0]           r_fill_cnt;
    logic                 w_fill_done;
    logic [1:0]           r_prev;
    logic                 w_step;
    logic                 w_err;
    logic                 w_dir_next;
    logic [CNT_WIDTH-1:0] w_pos_next;
    logic [CNT_WIDTH-1:0] r_position;
    logic                 r_step;
    logic                 r_dir;
    logic                 r_err;
    logic                 r_err_sticky;

    qdec_input_filter #(
        .FILT_CYCLES (FILT_CYCLES)
    ) u_filt_a (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (qbus.enc_a),
        .o_phase (w_a)
    );

    qdec_input_filter #(
        .FILT_CYCLES (FILT_CYCLES)
    ) u_filt_b (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (qbus.enc_b),
        .o_phase (w_b)
    );

    assign w_phase     = {w_a, w_b};
    // The fill counter saturates at FILL; that cycle is the last fill cycle.
    assign w_fill_done = (r_fill_cnt == 5'(FILL));

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: leave fill once the input pipeline holds real samples.
    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_FILL && w_fill_done) begin
            w_state_next = ST_TRACK;
        end
    end

    // FSM outputs: classify the phase transition while tracking.
    always_comb begin
        w_step     = 1'b0;
        w_err      = 1'b0;
        w_dir_next = r_dir;
        if (r_state == ST_TRACK && w_phase != r_prev) begin
            if ((w_phase ^ r_prev) == 2'b11) begin
                w_err = 1'b1;
            end else begin
                w_step     = 1'b1;
                w_dir_next = is_up_step(r_prev, w_phase);
            end
        end
    end

    // Position next value: clear > load > enabled step > hold, wrapping modulo 2^CNT_WIDTH.
    always_comb begin
        w_pos_next = r_position;
        if (qbus.clear) begin
            w_pos_next = '0;
        end else if (qbus.load) begin
            w_pos_next = qbus.load_value;
        end else if (qbus.enable && w_step) begin
            w_pos_next = w_dir_next ? r_position + 1'b1 : r_position - 1'b1;
        end
    end

    // Fill counter, previous phase and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fill_cnt   <= '0;
            r_prev       <= PH_00;
            r_step       <= 1'b0;
            r_dir        <= 1'b1;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_position   <= '0;
        end else begin
            if (r_state == ST_FILL && !w_fill_done) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end
            if (r_state == ST_TRACK || w_fill_done) begin
                r_prev <= w_phase;
            end
            r_step       <= w_step;
            r_dir        <= w_dir_next;
            r_err        <= w_err;
            // A new error outranks a same-cycle clear.
            r_err_sticky <= w_err | (r_err_sticky & ~qbus.clear);
            r_position   <= w_pos_next;
        end
    end

    assign qbus.position   = r_position;
    assign qbus.step       = r_step;
    assign qbus.dir        = r_dir;
    assign qbus.err        = r_err;
    assign qbus.err_sticky = r_err_sticky;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder; every step/err pulse is matched against a scoreboard.
// Optional feature macro: QDEC_GLITCH_FILTER_EN selects the filter latency and glitch tests.
module tb_quadrature_decoder;

`ifdef QDEC_GLITCH_FILTER_EN
    localparam int LATENCY = 6;
`else
    localparam int LATENCY = 3;
`endif

    typedef struct {
        bit       err;
        bit       dir;
        bit [7:0] pos;
    } sb_entry_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    sb_entry_t  sb[$];
    logic [1:0] m_ph;
    bit         m_dir;
    bit [7:0]   m_pos;
    bit         m_en;

    quadrature_decoder_if #(.CNT_WIDTH(8)) qb ();

    quadrature_decoder #(
        .CNT_WIDTH   (8),
        .FILT_CYCLES (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .qbus    (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every step or err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && (qb.step || qb.err)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: step=%0b err=%0b pos=%02h, none expected",
                         qb.step, qb.err, qb.position);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                if ({qb.step, qb.err, qb.dir, qb.position} !== {~e.err, e.err, e.dir, e.pos}) begin
                    errors++;
                    $display("FAIL event: got step=%0b err=%0b dir=%0b pos=%02h, want step=%0b err=%0b dir=%0b pos=%02h",
                             qb.step, qb.err, qb.dir, qb.position, ~e.err, e.err, e.dir, e.pos);
                end
            end
        end
    end

    function automatic int ph_idx(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Model one phase change and queue the event it should produce.
    task automatic expect_phase(input logic [1:0] nph);
        sb_entry_t e;
        int di, dn;
        if (nph != m_ph) begin
            di = ph_idx(m_ph);
            dn = ph_idx(nph);
            if (dn == (di + 2) % 4) begin
                e.err = 1'b1;
                e.dir = m_dir;
                e.pos = m_pos;
            end else begin
                e.err = 1'b0;
                m_dir = (dn == (di + 1) % 4);
                e.dir = m_dir;
                if (m_en) m_pos = m_dir ? m_pos + 8'd1 : m_pos - 8'd1;
                e.pos = m_pos;
            end
            sb.push_back(e);
        end
        m_ph = nph;
    endtask

    task automatic drive_phase(input logic [1:0] nph);
        expect_phase(nph);
        @(negedge clk);
        qb.enc_a = nph[1];
        qb.enc_b = nph[0];
        repeat (10) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d expected events never seen, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_pos(input string name, input logic [7:0] want);
        checks++;
        if (qb.position !== want) begin
            errors++;
            $display("FAIL %s: position=%02h, want %02h", name, qb.position, want);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        qb.enc_a = 1'b1;
        qb.enc_b = 1'b1;
        qb.enable = 1'b1;
        qb.clear = 1'b0;
        qb.load = 1'b0;
        qb.load_value = 8'h00;
        m_ph = 2'b11;
        m_dir = 1'b1;
        m_pos = 8'h00;
        m_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({qb.position, qb.step, qb.dir, qb.err, qb.err_sticky} !== {8'h00, 4'b0100}) begin
            errors++;
            $display("FAIL reset_values: pos=%02h step=%0b dir=%0b err=%0b sticky=%0b, want 00 0 1 0 0",
                     qb.position, qb.step, qb.dir, qb.err, qb.err_sticky);
        end
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if ({qb.position, qb.err_sticky} !== 9'h000) begin
            errors++;
            $display("FAIL after_fill: pos=%02h sticky=%0b, want 00 0", qb.position, qb.err_sticky);
        end
    endtask

    task automatic test_up_down();
        for (int i = 0; i < 16; i++) drive_phase(2'(ph_idx_up(m_ph)));
        check_pos("up_16", 8'd16);
        for (int i = 0; i < 16; i++) drive_phase(2'(ph_idx_dn(m_ph)));
        check_pos("down_16", 8'd0);
        check_drained("up_down");
    endtask

    function automatic logic [1:0] ph_idx_up(input logic [1:0] p);
        logic [1:0] seq [4];
        seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        return seq[(ph_idx(p) + 1) % 4];
    endfunction

    function automatic logic [1:0] ph_idx_dn(input logic [1:0] p);
        logic [1:0] seq [4];
        seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        return seq[(ph_idx(p) + 3) % 4];
    endfunction

    task automatic test_latency();
        int n;
        int lat;
        logic [1:0] nph;
        nph = ph_idx_up(m_ph);
        expect_phase(nph);
        @(negedge clk);
        qb.enc_a = nph[1];
        qb.enc_b = nph[0];
        lat = 0;
        n = 0;
        while (lat == 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (qb.step) lat = n;
        end
        checks++;
        if (lat != LATENCY) begin
            errors++;
            $display("FAIL step_latency: %0d edges, want %0d", lat, LATENCY);
        end
        repeat (10) @(negedge clk);
        check_drained("latency");
    endtask

    task automatic pulse_ctrl(input bit do_clear, input bit do_load, input logic [7:0] val);
        @(negedge clk);
        qb.load_value = val;
        qb.clear = do_clear;
        qb.load = do_load;
        @(negedge clk);
        qb.clear = 1'b0;
        qb.load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        pulse_ctrl(1'b0, 1'b1, 8'hFE);
        m_pos = 8'hFE;
        check_pos("load_fe", 8'hFE);
        for (int i = 0; i < 3; i++) drive_phase(ph_idx_up(m_ph));
        check_pos("wrap_up", 8'h01);
        pulse_ctrl(1'b1, 1'b0, 8'h00);
        m_pos = 8'h00;
        check_pos("clear", 8'h00);
        drive_phase(ph_idx_dn(m_ph));
        check_pos("wrap_down", 8'hFF);
        check_drained("wrap");
    endtask

    task automatic test_error();
        logic [7:0] held;
        while (m_ph != 2'b00) drive_phase(ph_idx_dn(m_ph));
        held = m_pos;
        drive_phase(2'b11);
        check_pos("err_pos_held", held);
        checks++;
        if (qb.err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky_set: sticky=%0b, want 1", qb.err_sticky);
        end
        pulse_ctrl(1'b1, 1'b0, 8'h00);
        m_pos = 8'h00;
        checks++;
        if ({qb.err_sticky, qb.position} !== 9'h000) begin
            errors++;
            $display("FAIL err_clear: sticky=%0b pos=%02h, want 0 00", qb.err_sticky, qb.position);
        end
        check_drained("error");
    endtask

    task automatic test_enable();
        qb.enable = 1'b0;
        m_en = 1'b0;
        for (int i = 0; i < 5; i++) drive_phase(ph_idx_up(m_ph));
        check_pos("disabled_hold", 8'h00);
        qb.enable = 1'b1;
        m_en = 1'b1;
        pulse_ctrl(1'b0, 1'b1, 8'h33);
        m_pos = 8'h33;
        pulse_ctrl(1'b1, 1'b1, 8'h5A);
        m_pos = 8'h00;
        check_pos("clear_beats_load", 8'h00);
        check_drained("enable");
    endtask

    task automatic test_clear_err();
        sb_entry_t e;
        logic [1:0] nph;
        pulse_ctrl(1'b0, 1'b1, 8'h33);
        nph = ~m_ph;
        e.err = 1'b1;
        e.dir = m_dir;
        e.pos = 8'h00;
        sb.push_back(e);
        @(negedge clk);
        qb.enc_a = nph[1];
        qb.enc_b = nph[0];
        repeat (2) @(negedge clk);
        qb.clear = 1'b1;
        @(negedge clk);
        qb.clear = 1'b0;
        m_ph = nph;
        m_pos = 8'h00;
        checks++;
        if ({qb.err_sticky, qb.position} !== 9'h100) begin
            errors++;
            $display("FAIL clear_and_err: sticky=%0b pos=%02h, want 1 00", qb.err_sticky, qb.position);
        end
        repeat (10) @(negedge clk);
        check_drained("clear_err");
    endtask

    task automatic test_mid_reset();
        drive_phase(ph_idx_dn(m_ph));
        check_pos("pre_reset", 8'hFF);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({qb.position, qb.dir, qb.err_sticky} !== 10'b00000000_1_0) begin
            errors++;
            $display("FAIL async_reset: pos=%02h dir=%0b sticky=%0b, want 00 1 0",
                     qb.position, qb.dir, qb.err_sticky);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_pos = 8'h00;
        m_dir = 1'b1;
        repeat (30) @(negedge clk);
        check_pos("refill_no_event", 8'h00);
        drive_phase(ph_idx_up(m_ph));
        check_pos("after_refill", 8'h01);
        check_drained("mid_reset");
    endtask

`ifdef QDEC_GLITCH_FILTER_EN
    task automatic test_filter();
        logic a0;
        a0 = m_ph[1];
        @(negedge clk);
        qb.enc_a = ~a0;
        repeat (2) @(negedge clk);
        qb.enc_a = a0;
        repeat (15) @(negedge clk);
        check_pos("glitch_ignored", m_pos);
        expect_phase({~a0, m_ph[0]});
        expect_phase({a0, m_ph[0]});
        @(negedge clk);
        qb.enc_a = ~a0;
        repeat (4) @(negedge clk);
        qb.enc_a = a0;
        repeat (15) @(negedge clk);
        check_pos("pulse_two_steps", m_pos);
        check_drained("filter");
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_up_down();
        test_latency();
        test_wrap();
        test_error();
        test_enable();
        test_clear_err();
        test_mid_reset();
`ifdef QDEC_GLITCH_FILTER_EN
        test_filter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
